stopwatch_display: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 43 ++++
 rtl/stopwatch_display_seg7.sv | 33 +++
 rtl/stopwatch_display.sv | 142 ++++++++++++++
 tb/tb_stopwatch_display.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants, FSM states and segment glyphs for the stopwatch display.
// Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
package stopwatch_pkg;

    localparam int SEC_MAX      = 999;
    localparam int FRAC_MAX     = 9;
    localparam int BIN_W        = 10;
    localparam int BCD_W        = 12;
    localparam int SHIFT_CYCLES = 10;
    localparam int SR_W         = BCD_W + BIN_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_SHIFT,
        S_UPDATE
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] bcd_adj3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_display_seg7.sv
// BCD digit to 7-segment glyph; codes 10-15 render blank.
// Polarity is applied by XOR with ACTIVE_LOW.
module seg7_encoder
    import stopwatch_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    logic [6:0] w_glyph;

    always_comb begin
        w_glyph = SEG_BLANK;
        case (i_bcd)
            4'd0:    w_glyph = SEG_0;
            4'd1:    w_glyph = SEG_1;
            4'd2:    w_glyph = SEG_2;
            4'd3:    w_glyph = SEG_3;
            4'd4:    w_glyph = SEG_4;
            4'd5:    w_glyph = SEG_5;
            4'd6:    w_glyph = SEG_6;
            4'd7:    w_glyph = SEG_7;
            4'd8:    w_glyph = SEG_8;
            4'd9:    w_glyph = SEG_9;
            default: w_glyph = SEG_BLANK;
        endcase
    end

    assign o_seg = w_glyph ^ {7{ACTIVE_LOW}};

endmodule

// File: rtl/stopwatch_display.sv
// Stopwatch seconds/fraction to four 7-segment digits via a
// sequential double-dabble converter with a tear-free output update.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int IN_W           = 32,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] seconds,
    input  logic [IN_W-1:0] m_seconds,
    output logic [6:0]      hex3,
    output logic [6:0]      hex2,
    output logic [6:0]      hex1,
    output logic [6:0]      hex0,
    output logic            busy,
    output logic            valid
);

    state_t            r_state;
    state_t            w_next;
    logic [BIN_W-1:0]  r_sec_snap;
    logic [3:0]        r_frac_snap;
    logic              r_done;
    logic [SR_W-1:0]   r_sr;
    logic [3:0]        r_cnt;
    logic              r_busy;
    logic              r_valid;
    logic [3:0]        r_d3;
    logic [3:0]        r_d2;
    logic [3:0]        r_d1;
    logic [3:0]        r_d0;

    logic [BIN_W-1:0]  w_sec_san;
    logic [3:0]        w_frac_san;
    logic              w_change;
    logic [BCD_W-1:0]  w_bcd;
    logic [SR_W-1:0]   w_sr_next;

    // Out-of-range inputs are transient counter glitches; show them as zero.
    always_comb begin
        w_sec_san  = '0;
        w_frac_san = '0;
        if (seconds <= IN_W'(SEC_MAX)) begin
            w_sec_san = seconds[BIN_W-1:0];
        end
        if (m_seconds <= IN_W'(FRAC_MAX)) begin
            w_frac_san = m_seconds[3:0];
        end
    end

    assign w_change = !r_done
                   || (w_sec_san  != r_sec_snap)
                   || (w_frac_san != r_frac_snap);

    assign w_bcd     = r_sr[SR_W-1:BIN_W];
    assign w_sr_next = {bcd_adj3(w_bcd), r_sr[BIN_W-1:0]} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_change) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_snap  <= '0;
            r_frac_snap <= '0;
            r_done      <= 1'b0;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_d3        <= '0;
            r_d2        <= '0;
            r_d1        <= '0;
            r_d0        <= '0;
        end else begin
            case (r_state)
                S_CAPTURE: begin
                    r_sec_snap  <= w_sec_san;
                    r_frac_snap <= w_frac_san;
                    r_done      <= 1'b1;
                    r_sr        <= {{BCD_W{1'b0}}, w_sec_san};
                    r_cnt       <= 4'(SHIFT_CYCLES);
                    r_busy      <= 1'b1;
                end
                S_SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt - 4'd1;
                end
                S_UPDATE: begin
                    r_d3    <= w_bcd[11:8];
                    r_d2    <= w_bcd[7:4];
                    r_d1    <= w_bcd[3:0];
                    r_d0    <= r_frac_snap;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;

    seg7_encoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc3 (.i_bcd(r_d3), .o_seg(hex3));
    seg7_encoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc2 (.i_bcd(r_d2), .o_seg(hex2));
    seg7_encoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc1 (.i_bcd(r_d1), .o_seg(hex1));
    seg7_encoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc0 (.i_bcd(r_d0), .o_seg(hex0));

endmodule

// File: tb/tb_stopwatch_display.sv
// Randomized self-checking bench for stopwatch_display against a
// decimal-arithmetic display model; drives active-low and active-high copies.
module tb_stopwatch_display;

    logic        clk;
    logic        rst_n;
    logic [31:0] seconds;
    logic [31:0] m_seconds;
    logic [6:0]  hex3, hex2, hex1, hex0;
    logic        busy, valid;
    logic [6:0]  hex3_h, hex2_h, hex1_h, hex0_h;
    logic        busy_h, valid_h;

    int n_total = 0;
    int n_bad   = 0;

    stopwatch_display #(.IN_W(32), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .seconds(seconds), .m_seconds(m_seconds),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .busy(busy), .valid(valid)
    );

    stopwatch_display #(.IN_W(32), .SEG_ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst_n(rst_n),
        .seconds(seconds), .m_seconds(m_seconds),
        .hex3(hex3_h), .hex2(hex2_h), .hex1(hex1_h), .hex0(hex0_h),
        .busy(busy_h), .valid(valid_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Active-high glyph, {g,f,e,d,c,b,a}, drawn from a standard 7-seg chart.
    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] glyph_lo(input int d);
        return ~glyph(d);
    endfunction

    function automatic logic is_digit_lo(input logic [6:0] x);
        for (int d = 0; d < 10; d++) begin
            if (x == glyph_lo(d)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk_disp(input string tag, input int s_raw, input int f_raw);
        int s, f;
        s = (s_raw > 999) ? 0 : s_raw;
        f = (f_raw > 9) ? 0 : f_raw;
        chk({tag, "_h3"}, hex3, glyph_lo(s / 100));
        chk({tag, "_h2"}, hex2, glyph_lo((s / 10) % 10));
        chk({tag, "_h1"}, hex1, glyph_lo(s % 10));
        chk({tag, "_h0"}, hex0, glyph_lo(f));
        chk({tag, "_hi3"}, hex3_h, glyph(s / 100));
        chk({tag, "_hi2"}, hex2_h, glyph((s / 10) % 10));
        chk({tag, "_hi1"}, hex1_h, glyph(s % 10));
        chk({tag, "_hi0"}, hex0_h, glyph(f));
    endtask

    task automatic settle(input int n);
        logic ok;
        repeat (n) begin
            @(negedge clk);
            ok = is_digit_lo(hex3) && is_digit_lo(hex2)
              && is_digit_lo(hex1) && is_digit_lo(hex0);
            chk("glyph_ok", 32'(ok), 32'd1);
        end
    endtask

    task automatic wait_busy(input string tag);
        int k;
        k = 0;
        while (!busy && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_busy_seen"}, 32'(busy), 32'd1);
    endtask

    initial begin
        int bcnt, rises, k;
        logic prev_b;
        logic [6:0] h1_start, h1_first, h1_last;
        logic first_seen;
        int rs, rf;

        rst_n     = 1'b0;
        seconds   = 32'd0;
        m_seconds = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_h3", hex3, 32'h40);
        chk("rst_h0", hex0, glyph_lo(0));
        chk("rst_hi2", hex2_h, glyph(0));
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);

        // First conversion after reset: busy must be high exactly 11 cycles.
        rst_n = 1'b1;
        bcnt = 0;
        k = 0;
        while (!valid && k < 40) begin
            @(negedge clk);
            if (busy) bcnt++;
            k++;
        end
        chk("first_valid", valid, 1);
        chk("first_busy_len", bcnt, 11);
        chk_disp("first", 0, 0);

        seconds = 123; m_seconds = 7;
        settle(30);
        chk("s123_h3", hex3, 32'h79);
        chk("s123_h2", hex2, 32'h24);
        chk("s123_h1", hex1, 32'h30);
        chk("s123_h0", hex0, 32'h78);
        chk_disp("s123", 123, 7);
        chk("s123_busy_idle", busy, 0);
        chk("s123_valid", valid, 1);

        seconds = 999; m_seconds = 9;
        settle(30);
        chk_disp("s999", 999, 9);
        seconds = 1000;
        settle(1);
        seconds = 0;
        settle(30);
        chk_disp("s1000", 0, 9);

        // 45 -> 46 during the third SHIFT cycle of the 45 conversion.
        seconds = 44; m_seconds = 1;
        settle(30);
        seconds = 45;
        wait_busy("mid");
        h1_start = hex1;
        repeat (2) @(negedge clk);
        seconds = 46;
        rises = 1;
        prev_b = busy;
        first_seen = 1'b0;
        h1_first = h1_start;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy && !prev_b) rises++;
            prev_b = busy;
            if (!first_seen && hex1 != h1_start) begin
                first_seen = 1'b1;
                h1_first = hex1;
            end
        end
        h1_last = hex1;
        chk("mid_first45", h1_first, glyph_lo(5));
        chk("mid_last46", h1_last, glyph_lo(6));
        chk("mid_busy_pulses", rises, 2);
        chk_disp("mid46", 46, 1);

        // Async reset on the fifth SHIFT cycle of a 500 conversion.
        seconds = 500; m_seconds = 3;
        wait_busy("arst");
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_h2", hex2, glyph_lo(0));
        chk("arst_h1", hex1, glyph_lo(0));
        chk("arst_h0", hex0, glyph_lo(0));
        chk("arst_busy", busy, 0);
        chk("arst_valid", valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        settle(30);
        chk_disp("arst500", 500, 3);
        chk("arst_valid2", valid, 1);

        seconds = 250; m_seconds = 12;
        settle(30);
        chk_disp("s250", 250, 12);

        for (int i = 0; i < 25; i++) begin
            rs = int'($urandom_range(0, 1100));
            rf = int'($urandom_range(0, 15));
            seconds = 32'(rs);
            m_seconds = 32'(rf);
            if ($urandom_range(0, 3) == 0) begin
                settle(int'($urandom_range(1, 11)));
                rs = int'($urandom_range(0, 999));
                seconds = 32'(rs);
            end
            settle(30);
            chk_disp("rand", rs, rf);
        end

        seconds = 32'hFFFF_FFFF; m_seconds = 32'h8000_0009;
        settle(30);
        chk_disp("huge", 32'h7FFF_FFFF, 10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
